// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive-to-word framer.
package uart_pkg;

  // Bit-level receiver states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int unsigned BAUD_DIV_DEFAULT     = 434;
  localparam int unsigned TIMEOUT_BITS_DEFAULT = 16;

  // Bit-time counter width; covers the full legal BAUD_DIV range
  localparam int unsigned BIT_CNT_W = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, bit-timing FSM, byte/frame-error pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       idle_o
);

  localparam int unsigned HALF_RELOAD = BAUD_DIV / 2 - 1;
  localparam int unsigned FULL_RELOAD = BAUD_DIV - 1;

  rx_state_e            state_q;
  logic                 sync1_q, sync2_q, prev_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic [2:0]           bit_q;
  logic [7:0]           shift_q;
  logic [7:0]           byte_q;
  logic                 byte_valid_q;
  logic                 frame_err_q;

  // Synchronizer, falling-edge history and bit-timing FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= rx_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A falling edge needs the line high first, so after a framing
          // error the receiver only re-arms once rx has returned to idle.
          if (prev_q && !sync2_q) begin
            state_q <= ST_START;
            cnt_q   <= BIT_CNT_W'(HALF_RELOAD);
          end
        end
        ST_START: begin
          if (cnt_q == '0) begin
            if (!sync2_q) begin
              state_q <= ST_DATA;
              cnt_q   <= BIT_CNT_W'(FULL_RELOAD);
              bit_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {sync2_q, shift_q[7:1]};
            cnt_q   <= BIT_CNT_W'(FULL_RELOAD);
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            if (sync2_q) begin
              byte_q       <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign idle_o       = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_rx_framer.sv
// Pairs received UART bytes into 16-bit words and hands them to an SPI stage.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = BAUD_DIV_DEFAULT,
  parameter int unsigned TIMEOUT_BITS = TIMEOUT_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        word_ack,
  output logic [15:0] word_data,
  output logic        word_valid,
  output logic        spi_start,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  logic [7:0]      rx_byte;
  logic            rx_byte_valid;
  logic            rx_frame_err;
  logic            rx_idle;

  logic            byte_idx_q;
  logic [7:0]      hi_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [15:0]     word_data_q;
  logic            word_valid_q;
  logic            spi_start_q;
  logic            overrun_q;
  logic            word_done_c;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx_byte (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .frame_err_o  (rx_frame_err),
    .idle_o       (rx_idle)
  );

  assign word_done_c = rx_byte_valid && byte_idx_q;

  // Byte pairing, stale-half-word timeout and downstream handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_q   <= 1'b0;
      hi_q         <= '0;
      to_cnt_q     <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      spi_start_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (rx_frame_err) begin
        byte_idx_q <= 1'b0;
        to_cnt_q   <= '0;
      end else if (rx_byte_valid) begin
        byte_idx_q <= ~byte_idx_q;
        to_cnt_q   <= '0;
        if (!byte_idx_q) begin
          hi_q <= rx_byte;
        end
      end else if (byte_idx_q && rx_idle) begin
        // Half a word has sat idle too long: drop it silently
        if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
          byte_idx_q <= 1'b0;
          to_cnt_q   <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end

      // An ack in the completion cycle frees the slot for the new word
      if (word_done_c) begin
        if (!word_valid_q || word_ack) begin
          word_data_q  <= {hi_q, rx_byte};
          word_valid_q <= 1'b1;
          spi_start_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (word_ack && word_valid_q) begin
        word_valid_q <= 1'b0;
      end
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign spi_start  = spi_start_q;
  assign frame_err  = rx_frame_err;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at BAUD_DIV=16, TIMEOUT_BITS=16.
module tb_uart_rx_framer;

  localparam int unsigned BIT_CYC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        word_ack;
  logic [15:0] word_data;
  logic        word_valid;
  logic        spi_start;
  logic        frame_err;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int spi_cnt = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  int long_cnt = 0;
  logic spi_prev = 1'b0;
  logic ovr_prev = 1'b0;
  logic fe_prev  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_framer #(
    .BAUD_DIV     (16),
    .TIMEOUT_BITS (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .word_ack   (word_ack),
    .word_data  (word_data),
    .word_valid (word_valid),
    .spi_start  (spi_start),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  // Pulse counting plus a check that no pulse lasts two cycles
  always @(negedge clk) begin
    if (spi_start) spi_cnt <= spi_cnt + 1;
    if (overrun)   ovr_cnt <= ovr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if ((spi_start && spi_prev) || (overrun && ovr_prev) || (frame_err && fe_prev))
      long_cnt <= long_cnt + 1;
    spi_prev <= spi_start;
    ovr_prev <= overrun;
    fe_prev  <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame for ncyc cycles; optionally ack in the word-completion cycle
  task automatic send_byte(input logic [7:0] d, input logic stop_bit,
                           input logic ack_on_done, input int ncyc);
    logic [7:0] dv;
    dv = d;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i < 16)       rx = 1'b0;
      else if (i < 144) rx = dv[3'((i - 16) / 16)];
      else              rx = stop_bit;
      word_ack = ack_on_done && (i == 155);
    end
    word_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    send_byte(d, 1'b1, 1'b0, 10 * BIT_CYC);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic ack_and_check(input string tag);
    @(negedge clk);
    word_ack = 1'b1;
    @(negedge clk);
    word_ack = 1'b0;
    check(tag, 32'(word_valid), 32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    rx       = 1'b1;
    word_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",    32'(word_data),  32'h0);
    check("rst_valid",   32'(word_valid), 32'h0);
    check("rst_spi",     32'(spi_start),  32'h0);
    check("rst_ferr",    32'(frame_err),  32'h0);
    check("rst_overrun", 32'(overrun),    32'h0);
    reset = 1'b0;
    idle(20);

    // Basic word
    send(8'hA5);
    send(8'h3C);
    check("basic_data",  32'(word_data),  32'hA53C);
    check("basic_valid", 32'(word_valid), 32'h1);
    check("basic_spi",   32'(spi_cnt),    32'd1);
    ack_and_check("basic_ack");
    idle(10);

    // Short low glitch is rejected
    repeat (5) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(40);
    check("glitch_ferr",  32'(ferr_cnt),   32'd0);
    check("glitch_valid", 32'(word_valid), 32'h0);
    send(8'h12);
    send(8'h34);
    check("glitch_data", 32'(word_data), 32'h1234);
    check("glitch_spi",  32'(spi_cnt),   32'd2);
    ack_and_check("glitch_ack");

    // Framing error on the second byte restarts pairing
    send(8'h99);
    send_byte(8'h55, 1'b0, 1'b0, 10 * BIT_CYC);
    check("ferr_pulse", 32'(ferr_cnt),   32'd1);
    check("ferr_valid", 32'(word_valid), 32'h0);
    idle(40);
    send(8'hBE);
    send(8'hEF);
    check("ferr_data", 32'(word_data), 32'hBEEF);
    check("ferr_spi",  32'(spi_cnt),   32'd3);
    ack_and_check("ferr_ack");

    // Overrun, then replacement with ack in the completion cycle
    send(8'h11);
    send(8'h22);
    check("ovr_first_data", 32'(word_data), 32'h1122);
    check("ovr_first_spi",  32'(spi_cnt),   32'd4);
    send(8'h33);
    send(8'h44);
    check("ovr_held_data", 32'(word_data),  32'h1122);
    check("ovr_pulse",     32'(ovr_cnt),    32'd1);
    check("ovr_no_spi",    32'(spi_cnt),    32'd4);
    check("ovr_valid",     32'(word_valid), 32'h1);
    send(8'h55);
    send_byte(8'h66, 1'b1, 1'b1, 10 * BIT_CYC);
    check("ackdone_data",  32'(word_data),  32'h5566);
    check("ackdone_valid", 32'(word_valid), 32'h1);
    check("ackdone_spi",   32'(spi_cnt),    32'd5);
    check("ackdone_ovr",   32'(ovr_cnt),    32'd1);
    ack_and_check("ackdone_ack");

    // Half word times out after 16 idle bit-times
    send(8'h77);
    idle(17 * BIT_CYC);
    send(8'h01);
    send(8'h02);
    check("timeout_data", 32'(word_data), 32'h0102);
    check("timeout_spi",  32'(spi_cnt),   32'd6);
    ack_and_check("timeout_ack");

    // Reset mid-byte with a valid word and a pending high byte
    send(8'h12);
    send(8'h34);
    check("prerst_valid", 32'(word_valid), 32'h1);
    send(8'hAB);
    send_byte(8'hCD, 1'b1, 1'b0, 5 * BIT_CYC + 8);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_data",    32'(word_data),  32'h0);
    check("midrst_valid",   32'(word_valid), 32'h0);
    check("midrst_spi",     32'(spi_start),  32'h0);
    check("midrst_ferr",    32'(frame_err),  32'h0);
    check("midrst_overrun", 32'(overrun),    32'h0);
    reset = 1'b0;
    idle(20);
    send(8'hC0);
    send(8'hDE);
    check("postrst_data",  32'(word_data),  32'hC0DE);
    check("postrst_valid", 32'(word_valid), 32'h1);
    check("postrst_spi",   32'(spi_cnt),    32'd8);
    check("postrst_ovr",   32'(ovr_cnt),    32'd1);
    check("total_ferr",    32'(ferr_cnt),   32'd1);
    check("pulse_width",   32'(long_cnt),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
